// File: rtl/map_pkg.sv
// Shared constants and types for the maze tile-map arbiter.
// Map geometry is 80 x 60 tiles, one 4-bit code per tile, stored row-major.
package map_pkg;

    localparam int MAP_W  = 80;
    localparam int MAP_H  = 60;
    localparam int ADDR_W = 13;
    localparam int TX_W   = 7;
    localparam int TY_W   = 6;
    localparam int CODE_W = 4;

    // Codes 0000..0111 are wall shapes; the upper half holds the walkable tiles.
    localparam logic [CODE_W-1:0] TILE_WALL_MAX = 4'b0111;
    localparam logic [CODE_W-1:0] TILE_BLANK    = 4'b1000;
    localparam logic [CODE_W-1:0] TILE_CANDY    = 4'b1001;
    localparam logic [CODE_W-1:0] TILE_POWER    = 4'b1010;

    // The fourth encoding is decoded as a plain read.
    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_WRITE    = 2'b01,
        OP_EAT      = 2'b10,
        OP_READ_ALT = 2'b11
    } game_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDWAIT,
        ST_WB,
        ST_RESP
    } arb_state_t;

    // Tiles that an EAT consumes (replaced by a blank tile).
    function automatic logic is_edible(input logic [CODE_W-1:0] code);
        return (code == TILE_CANDY) || (code == TILE_POWER);
    endfunction

endpackage

// File: rtl/map_addr_calc.sv
// Tile coordinate to linear RAM address (ty * 80 + tx), with optional
// out-of-bounds detection. With CHECK_EN = 0 the oob output is constant 0.
module map_addr_calc
    import map_pkg::*;
#(
    parameter bit CHECK_EN = 1'b0
)
(
    input  logic [TX_W-1:0]   tx,
    input  logic [TY_W-1:0]   ty,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    // Largest input (63 * 80 + 127 = 5167) still fits in 13 bits, so no wrap.
    always_comb begin
        addr = ADDR_W'(ty) * ADDR_W'(MAP_W) + ADDR_W'(tx);
        oob  = CHECK_EN && ((tx >= TX_W'(MAP_W)) || (ty >= TY_W'(MAP_H)));
    end

endmodule

// File: rtl/map_tile_arbiter.sv
// Arbitrates a single-port tile-map RAM between the video renderer (fixed
// 2-cycle lookup, absolute priority) and the game logic (READ / WRITE / EAT
// transactions with a completion pulse).
// Optional feature: define MAP_ARB_BOUNDS_EN to reject out-of-map coordinates
// (no RAM access, blank tile returned, oob_err pulsed with the result).
module map_tile_arbiter
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    // renderer lookup port
    input  logic              render_req,
    input  logic [TX_W-1:0]   render_tx,
    input  logic [TY_W-1:0]   render_ty,
    output logic [CODE_W-1:0] render_code,
    output logic              render_code_valid,
    // game logic port
    input  logic              game_req,
    input  logic [1:0]        game_op,
    input  logic [TX_W-1:0]   game_tx,
    input  logic [TY_W-1:0]   game_ty,
    input  logic [CODE_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic [CODE_W-1:0] game_rdata,
    // tile RAM (1-cycle read latency)
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CODE_W-1:0] ram_wdata,
    input  logic [CODE_W-1:0] ram_rdata,
    // bounds error pulse
    output logic              oob_err
);

`ifdef MAP_ARB_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] render_addr;
    logic              render_oob;
    logic [ADDR_W-1:0] game_addr;
    logic              game_oob;

    map_addr_calc #(.CHECK_EN(BOUNDS_EN)) u_render_addr (
        .tx   (render_tx),
        .ty   (render_ty),
        .addr (render_addr),
        .oob  (render_oob)
    );

    map_addr_calc #(.CHECK_EN(BOUNDS_EN)) u_game_addr (
        .tx   (game_tx),
        .ty   (game_ty),
        .addr (game_addr),
        .oob  (game_oob)
    );

    // Game transaction state; fields are latched at accept time in IDLE.
    arb_state_t        state_q, state_d;
    game_op_t          op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              oob_q, oob_d;
    logic [CODE_W-1:0] hold_q, hold_d;

    // Render pipeline: owner flag (render issued last cycle), its oob flag,
    // then the result stage seen by the renderer.
    logic              owner_q, owner_d;
    logic              r_oob_q, r_oob_d;
    logic [CODE_W-1:0] r_code_q, r_code_d;
    logic              r_valid_q, r_valid_d;
    logic              r_err_q, r_err_d;

    // Game-side RAM request and handshake, decoded from the FSM.
    logic              g_en;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [CODE_W-1:0] g_wdata;
    logic              gnt;

    // State registers for the game FSM and the render pipeline.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            oob_q     <= 1'b0;
            hold_q    <= '0;
            owner_q   <= 1'b0;
            r_oob_q   <= 1'b0;
            r_code_q  <= '0;
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            oob_q     <= oob_d;
            hold_q    <= hold_d;
            owner_q   <= owner_d;
            r_oob_q   <= r_oob_d;
            r_code_q  <= r_code_d;
            r_valid_q <= r_valid_d;
            r_err_q   <= r_err_d;
        end
    end

    // Game FSM: next state, latched fields and the game's RAM request.
    // NOTE: every signal gets a default at the top of an always_comb so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        oob_d   = oob_q;
        hold_d  = hold_q;
        g_en    = 1'b0;
        g_we    = 1'b0;
        g_addr  = addr_q;
        g_wdata = TILE_BLANK;
        gnt     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The renderer owns the RAM whenever it asks; the game waits.
                if (game_req && !render_req) begin
                    op_d   = game_op_t'(game_op);
                    addr_d = game_addr;
                    oob_d  = game_oob;
                    g_en   = !game_oob;
                    g_addr = game_addr;
                    if (game_op_t'(game_op) == OP_WRITE) begin
                        g_we    = 1'b1;
                        g_wdata = game_wdata;
                        hold_d  = game_oob ? TILE_BLANK : game_wdata;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end

            ST_RDWAIT: begin
                // Previous cycle was the game's read, so the owner flag is clear
                // and ram_rdata belongs to the game.
                if (!owner_q) begin
                    hold_d = oob_q ? TILE_BLANK : ram_rdata;
                end
                if (op_q == OP_EAT && !oob_q && is_edible(ram_rdata)) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_RESP;
                end
            end

            ST_WB: begin
                // Clear the eaten tile once the renderer leaves the port free.
                if (!render_req) begin
                    g_en    = 1'b1;
                    g_we    = 1'b1;
                    g_wdata = TILE_BLANK;
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                gnt     = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Render pipeline: issue in N, data returns in N+1, result visible in N+2.
    always_comb begin
        owner_d   = render_req;
        r_oob_d   = render_req && render_oob;
        r_valid_d = owner_q;
        r_err_d   = owner_q && r_oob_q;
        r_code_d  = r_code_q;
        if (owner_q) begin
            r_code_d = r_oob_q ? TILE_BLANK : ram_rdata;
        end
    end

    // RAM port mux: render first, then the game; all zero while in reset.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n) begin
            if (render_req) begin
                ram_en   = !render_oob;
                ram_addr = render_addr;
            end else if (g_en) begin
                ram_en    = 1'b1;
                ram_we    = g_we;
                ram_addr  = g_addr;
                ram_wdata = g_we ? g_wdata : '0;
            end
        end
    end

    // Output decode; everything derives from reset-cleared registers.
    always_comb begin
        render_code       = r_code_q;
        render_code_valid = r_valid_q;
        game_gnt          = gnt;
        game_rdata        = gnt ? hold_q : '0;
        oob_err           = r_err_q || (gnt && oob_q);
    end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// Self-checking bench for map_tile_arbiter: directed scenarios plus random
// render/game traffic against a tile-map reference model.
// Build with +define+MAP_ARB_BOUNDS_EN to also exercise the bounds feature.
`timescale 1ns/1ps
module tb_map_tile_arbiter;

`ifdef MAP_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        render_req;
    logic [6:0]  render_tx;
    logic [5:0]  render_ty;
    logic [3:0]  render_code;
    logic        render_code_valid;
    logic        game_req;
    logic [1:0]  game_op;
    logic [6:0]  game_tx;
    logic [5:0]  game_ty;
    logic [3:0]  game_wdata;
    logic        game_gnt;
    logic [3:0]  game_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata;
    logic        oob_err;

    map_tile_arbiter dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .render_req        (render_req),
        .render_tx         (render_tx),
        .render_ty         (render_ty),
        .render_code       (render_code),
        .render_code_valid (render_code_valid),
        .game_req          (game_req),
        .game_op           (game_op),
        .game_tx           (game_tx),
        .game_ty           (game_ty),
        .game_wdata        (game_wdata),
        .game_gnt          (game_gnt),
        .game_rdata        (game_rdata),
        .ram_en            (ram_en),
        .ram_we            (ram_we),
        .ram_addr          (ram_addr),
        .ram_wdata         (ram_wdata),
        .ram_rdata         (ram_rdata),
        .oob_err           (oob_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment: the physical tile RAM (1-cycle read latency).
    logic [3:0] mem [8192];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model: the map contents as the game logic should see them.
    logic [3:0] ref_map [8192];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Render monitor: every render must hit the RAM in the same cycle and
    // deliver the map code exactly two cycles later, never otherwise.
    bit         pv [2];
    logic [3:0] pc [2];
    bit         po [2];
    bit         game_oob_exp = 1'b0;

    always @(negedge clk) begin
        int a;
        bit oob;
        if (!rst_n) begin
            pv[0] = 0; pv[1] = 0; po[0] = 0; po[1] = 0;
        end else begin
            check("render_valid", render_code_valid, pv[1]);
            if (pv[1]) check("render_code", render_code, pc[1]);
            check("oob_err", oob_err, po[1] | (game_gnt & game_oob_exp));
            pv[1] = pv[0]; pc[1] = pc[0]; po[1] = po[0];
            pv[0] = 0; po[0] = 0;
            if (render_req) begin
                a   = int'(render_ty) * 80 + int'(render_tx);
                oob = BOUNDS && (render_tx >= 80 || render_ty >= 60);
                if (oob) begin
                    check("render_oob_ram_en", ram_en, 0);
                end else begin
                    check("render_ram_en", ram_en, 1);
                    check("render_ram_we", ram_we, 0);
                    check("render_ram_addr", ram_addr, a);
                end
                pv[0] = 1;
                pc[0] = oob ? 4'h8 : ref_map[a];
                po[0] = oob;
            end
        end
    end

    // One complete game transaction; expectations come from ref_map.
    // exp_lat <= 0 skips the latency check (render contention).
    task automatic do_game(input logic [1:0] op, input int tx, input int ty,
                           input logic [3:0] wd, input int exp_lat);
        int a;
        int lat;
        bit oob;
        bit got;
        logic [3:0] pre;
        logic [3:0] exp_rd;
        logic [3:0] post;
        a   = ty * 80 + tx;
        oob = BOUNDS && (tx >= 80 || ty >= 60);
        pre = oob ? 4'h8 : ref_map[a];
        if (op == 2'b01) begin
            exp_rd = oob ? 4'h8 : wd;
            post   = wd;
        end else begin
            exp_rd = pre;
            post   = (op == 2'b10 && (pre == 4'h9 || pre == 4'hA)) ? 4'h8 : pre;
        end
        game_oob_exp = oob;
        game_req   = 1'b1;
        game_op    = op;
        game_tx    = 7'(tx);
        game_ty    = 6'(ty);
        game_wdata = wd;
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (game_gnt) got = 1;
        end
        check("game_gnt_seen", got, 1);
        if (got) begin
            check("game_rdata", game_rdata, exp_rd);
            if (exp_lat > 0) check("game_latency", lat, exp_lat);
            if (!oob) ref_map[a] = post;
        end
        next_cycle();
        game_req     = 1'b0;
        game_oob_exp = 1'b0;
    endtask

    bit stop_render;

    initial begin
        int a;
        int bad;
        logic [3:0] v;

        rst_n = 1'b0;
        render_req = 1'b1; render_tx = 7'd1; render_ty = 6'd1;
        game_req = 1'b0; game_op = 2'b00; game_tx = '0; game_ty = '0; game_wdata = '0;
        for (int i = 0; i < 8192; i++) begin
            v = 4'($urandom_range(0, 10));
            mem[i] = v;
            ref_map[i] = v;
        end

        // Reset: all outputs low even with a render request pending.
        #12;
        check("rst_ram_en", ram_en, 0);
        check("rst_render_valid", render_code_valid, 0);
        check("rst_render_code", render_code, 0);
        check("rst_game_gnt", game_gnt, 0);
        check("rst_game_rdata", game_rdata, 0);
        check("rst_oob_err", oob_err, 0);
        render_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("idle_ram_en", ram_en, 0);

        // Render at (3,2) -> address 163, code back two cycles later.
        mem[163] = 4'b0101; ref_map[163] = 4'b0101;
        next_cycle();
        render_req = 1'b1; render_tx = 7'd3; render_ty = 6'd2;
        next_cycle();
        render_req = 1'b0;
        repeat (3) next_cycle();

        // EAT on candy: write-back of blank, 4-cycle latency.
        mem[410] = 4'b1001; ref_map[410] = 4'b1001;
        do_game(2'b10, 10, 5, 4'h0, 4);
        check("eat_hit_ram", mem[410], 4'b1000);

        // EAT on wall: no write, 3-cycle latency.
        mem[572] = 4'b0010; ref_map[572] = 4'b0010;
        do_game(2'b10, 12, 7, 4'h0, 3);
        check("eat_wall_ram", mem[572], 4'b0010);

        // Plain WRITE, READ and the alternate-read encoding.
        do_game(2'b01, 15, 33, 4'h3, 2);
        check("write_ram", mem[33 * 80 + 15], 4'h3);
        do_game(2'b00, 15, 33, 4'h0, 3);
        do_game(2'b11, 16, 33, 4'h0, 3);

        // WRITE while render holds the port for 5 cycles.
        fork
            begin
                render_req = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    render_tx = 7'($urandom_range(0, 79));
                    render_ty = 6'($urandom_range(0, 29));
                    next_cycle();
                end
                render_req = 1'b0;
            end
            do_game(2'b01, 33, 44, 4'h6, 7);
        join
        check("contended_write_ram", mem[44 * 80 + 33], 4'h6);

        // Render between an EAT's read and its write-back sees the old code.
        mem[3220] = 4'b1001; ref_map[3220] = 4'b1001;
        fork
            do_game(2'b10, 20, 40, 4'h0, 4);
            begin
                next_cycle();
                render_req = 1'b1; render_tx = 7'd20; render_ty = 6'd40;
                next_cycle();
                render_req = 1'b0;
            end
        join
        check("eat_after_render_ram", mem[3220], 4'b1000);

        // Render stalling the write-back: EAT completes once render drops.
        mem[3621] = 4'b1010; ref_map[3621] = 4'b1010;
        fork
            do_game(2'b10, 21, 45, 4'h0, 6);
            begin
                next_cycle();
                next_cycle();
                render_req = 1'b1; render_tx = 7'd5; render_ty = 6'd3;
                next_cycle();
                next_cycle();
                render_req = 1'b0;
            end
        join
        check("eat_stalled_wb_ram", mem[3621], 4'b1000);

        // Reset during RDWAIT of an EAT: abandoned, no write-back.
        a = 50 * 80 + 30;
        mem[a] = 4'b1010; ref_map[a] = 4'b1010;
        game_req = 1'b1; game_op = 2'b10; game_tx = 7'd30; game_ty = 6'd50;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_gnt", game_gnt, 0);
        check("midrst_ram_en", ram_en, 0);
        check("midrst_ram_we", ram_we, 0);
        check("midrst_render_valid", render_code_valid, 0);
        game_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        repeat (3) next_cycle();
        check("midrst_ram_kept", mem[a], 4'b1010);
        do_game(2'b00, 30, 50, 4'h0, 3);

`ifdef MAP_ARB_BOUNDS_EN
        // Out-of-map render and game accesses return blank with oob_err.
        next_cycle();
        render_req = 1'b1; render_tx = 7'd85; render_ty = 6'd2;
        next_cycle();
        render_req = 1'b0;
        repeat (3) next_cycle();
        do_game(2'b00, 90, 10, 4'h0, 3);
        v = mem[10 * 80 + 90];
        do_game(2'b01, 90, 10, 4'h5, 2);
        check("oob_write_ram", mem[10 * 80 + 90], v);
        do_game(2'b10, 3, 61, 4'h0, 3);
`endif

        // Random traffic: renders in rows 0-29, game ops in rows 30-59.
        stop_render = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    do_game(2'($urandom_range(0, 3)), $urandom_range(0, 79),
                            $urandom_range(30, 59), 4'($urandom_range(0, 10)), 0);
                end
                stop_render = 1'b1;
            end
            begin
                while (!stop_render) begin
                    render_req = ($urandom_range(0, 99) < 40);
                    render_tx  = 7'($urandom_range(0, 79));
                    render_ty  = 6'($urandom_range(0, 29));
                    next_cycle();
                end
                render_req = 1'b0;
            end
        join
        repeat (4) next_cycle();

        // Final map image must match the model.
        bad = 0;
        for (int i = 0; i < 80 * 60; i++) begin
            if (mem[i] !== ref_map[i]) bad++;
        end
        check("ram_image_mismatches", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
